iram_access_ctrl: RTL and testbench
===================================

// Module: iram_access_ctrl
// PURPOSE
//  Sequences all accesses to the instruction RAM and shares its single address/data port between two requesters.
//  Requester 1 is the CPU fetch stage, which only reads; requester 2 is the program loader, which only writes.
//  The block arbitrates per cycle, drives iram address/read_not_write, and drives the inout data bus only on writes.
//  It returns fetched instructions with fixed latency, so the fetch stage can issue one read per cycle (PC = PC + 1).
// PARAMETERS
//  ADDRESS_BUS_WIDTH  24  address width; taken from params.v
//  INSTRUCTION_WIDTH  36  instruction word width; taken from params.v
//  IRAM_DEPTH         64  number of implemented instruction words; valid addresses are 0..IRAM_DEPTH-1
//  MAX_LOAD_RUN       4   max consecutive loader grants while a fetch is waiting (range 1..15)
// PORTS
//  clk          in   1    clock; all state updates on posedge
//  rst_n        in   1    asynchronous reset, active low
//  fetch_req    in   1    fetch stage requests a read at fetch_addr
//  fetch_addr   in   AW   instruction address to read
//  fetch_gnt    out  1    this cycle's fetch_req is accepted (combinational from the grant decision)
//  fetch_valid  out  1    fetch_instr holds read data; high 2 cycles after the accepting cycle
//  fetch_instr  out  IW   returned instruction word
//  fetch_err    out  1    with fetch_valid: address was out of range; fetch_instr = 0
//  load_req     in   1    loader requests a write of load_data at load_addr
//  load_addr    in   AW   write address
//  load_data    in   IW   write data
//  load_gnt     out  1    this cycle's load_req is accepted; the write completes at the next posedge
//  load_err     out  1    with load_gnt: address was out of range; no write is performed
//  iram_addr    out  AW   iram address
//  iram_rnw     out  1    1 = read, 0 = write; idle value is 1
//  iram_data    inout IW  driven only when iram_rnw = 0, otherwise hi-Z; iram drives it only when read_not_write = 1
// BEHAVIOUR
//  Reset (async, rst_n = 0):
//   - fetch_valid, fetch_err and load_err are 0; fetch_instr is 0.
//   - iram_rnw is forced to 1 and iram_data goes hi-Z immediately (not at the next edge).
//   - The grant state returns to G_IDLE, the run counter clears to 0, and in-flight reads are discarded.
//   - The gnt outputs are 0 while in reset.
//  Grant states: G_IDLE, G_FETCH, G_LOAD; the state register holds the grant decided for the current cycle.
//   - Loader has priority: load_req wins unless fetch_req=1 and run_cnt==MAX_LOAD_RUN; then fetch wins for one cycle.
//   - run_cnt increments on each load grant while fetch_req=1.
//   - run_cnt clears on any fetch grant, and clears whenever fetch_req=0.
//   - No requests: G_IDLE; iram_rnw=1; iram_addr holds its last value.
//  Read pipeline (cycle T = cycle in which fetch_gnt=1):
//   - T: iram_addr=fetch_addr, iram_rnw=1.
//   - T+1: iram returns the registered word on iram_data.
//   - Captured at the end of T+1; fetch_valid=1 and fetch_instr valid during T+2.
//   - Fully pipelined: back-to-back grants give back-to-back fetch_valid.
//   - Fetch data is tracked in a 2-entry valid/err shift pipe. When no fetch is granted, a 0 enters the pipe.
//  Write (cycle T = cycle in which load_gnt=1):
//   - T: iram_addr=load_addr, iram_rnw=0, iram_data=load_data; the iram writes at the end of T.
//   - T+1: the bus is hi-Z again unless another load is granted.
//   - Write then read of the same address in T+1 returns the new data.
//   - Bus turnaround is handled by iram: read driver gated by read_not_write, so no dead cycle is needed.
//  Range checks use addr >= IRAM_DEPTH:
//   - Fetch out of range: still granted, but iram is not accessed (rnw=1). It returns fetch_err=1 and fetch_instr=0 with the normal 2-cycle latency.
//   - Load out of range: granted with load_err=1, and iram_rnw stays 1 (the write is dropped).
//  Both requests tied high forever: steady pattern of MAX_LOAD_RUN loads, then 1 fetch, repeating.
//  Reset mid-write: no guarantee the word is written; the iram bus is released asynchronously.
// STRUCTURE
//  - params.v: add IRAM_DEPTH and the G_IDLE/G_FETCH/G_LOAD encodings (2-bit); widths already live there.
//  - Sub-module iram_arb_prio: combinational grant decision plus the run_cnt register (4 bits). Everything else is top level.
//  - Top level holds the grant state register, the read pipe and the tristate driver.
// TESTING
//  - Reset: assert rst_n=0 mid-write -> iram_rnw=1 and iram_data=Z within the same cycle; all valids 0 after release.
//  - Load then fetch: load 0x011000010 @0 and 0x012000020 @1, then fetch 0,1 back-to-back -> fetch_valid on 2 consecutive cycles with those words, 2 cycles after each gnt.
//  - Write/read hazard: load 0x052210000 @5 at T, fetch 5 at T+1 -> fetch_instr=0x052210000 at T+3.
//  - Starvation: fetch_req and load_req held high for 15 cycles, MAX_LOAD_RUN=4 -> gnt pattern LLLLF LLLLF LLLLF.
//  - Range: fetch @64 -> fetch_err=1 and fetch_instr=0 at T+2; load @70 -> load_err=1, iram_rnw stays 1, and memory is unchanged (checked by read-back).
//  - Idle: no requests for 10 cycles -> iram_rnw=1, iram_data never driven by the controller, no valids.

Source files
------------

// File: rtl/iram_access_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// iram_access_ctrl_pkg
//   Shared constants and types for the instruction-RAM access controller.
//   Holds the default bus widths, the implemented iram depth, the default
//   loader run limit and the 2-bit grant-state encoding used by both the
//   arbiter and the top level.
// ----------------------------------------------------------------------------
package iram_access_ctrl_pkg;

    localparam int DEF_ADDRESS_BUS_WIDTH = 24;
    localparam int DEF_INSTRUCTION_WIDTH = 36;
    localparam int DEF_IRAM_DEPTH        = 64;
    localparam int DEF_MAX_LOAD_RUN      = 4;
    localparam int RUN_CNT_WIDTH         = 4;

    // Grant decision for one cycle; the top-level state register keeps it.
    typedef enum logic [1:0] {
        G_IDLE  = 2'b00,
        G_FETCH = 2'b01,
        G_LOAD  = 2'b10
    } grant_e;

    // Keeps the run limit inside what the 4-bit run counter can reach, so a
    // bad parameter can never lock the fetch stage out entirely.
    function automatic logic [RUN_CNT_WIDTH-1:0] clampRun(input int maxRun);
        logic [RUN_CNT_WIDTH-1:0] limit;
        if (maxRun < 1) begin
            limit = RUN_CNT_WIDTH'(1);
        end else if (maxRun > 15) begin
            limit = RUN_CNT_WIDTH'(15);
        end else begin
            limit = RUN_CNT_WIDTH'(maxRun);
        end
        return limit;
    endfunction

endpackage

// File: rtl/iram_access_ctrl_arb_prio.sv
// ----------------------------------------------------------------------------
// iram_arb_prio
//   Per-cycle grant decision between the fetch stage (reader) and the program
//   loader (writer). The loader normally wins; the run counter bounds how many
//   loader grants in a row a waiting fetch can be made to sit through.
//
//   Ports
//     i_clk        clock, state updates on posedge
//     i_rst_n      asynchronous reset, active low
//     i_fetch_req  fetch stage wants a read this cycle
//     i_load_req   loader wants a write this cycle
//     o_grant      combinational grant decision for this cycle
// ----------------------------------------------------------------------------
module iram_arb_prio
    import iram_access_ctrl_pkg::*;
#(
    parameter int MAX_LOAD_RUN = DEF_MAX_LOAD_RUN
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_fetch_req,
    input  logic   i_load_req,
    output grant_e o_grant
);

    localparam logic [RUN_CNT_WIDTH-1:0] RUN_LIMIT = clampRun(MAX_LOAD_RUN);

    logic [RUN_CNT_WIDTH-1:0] r_runCnt;
    logic                     w_fetchStarved;
    grant_e                   w_grant;

    // Once the fetch stage has waited through RUN_LIMIT loader grants it
    // takes the next cycle, whatever the loader is doing.
    assign w_fetchStarved = i_fetch_req && (r_runCnt == RUN_LIMIT);

    always_comb begin
        w_grant = G_IDLE;
        if (i_load_req && !w_fetchStarved) begin
            w_grant = G_LOAD;
        end else if (i_fetch_req) begin
            w_grant = G_FETCH;
        end
    end

    // Counts loader grants only while a fetch is actually waiting; it can
    // never pass RUN_LIMIT because the fetch wins at that value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_runCnt <= '0;
        end else if (!i_fetch_req || (w_grant == G_FETCH)) begin
            r_runCnt <= '0;
        end else if (w_grant == G_LOAD) begin
            r_runCnt <= r_runCnt + RUN_CNT_WIDTH'(1);
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/iram_access_ctrl.sv
// ----------------------------------------------------------------------------
// iram_access_ctrl
//   Shares the single address/data port of the instruction RAM between the
//   CPU fetch stage (reads only) and the program loader (writes only). One
//   requester is granted per cycle; reads return with a fixed 2-cycle latency
//   and are fully pipelined, writes complete at the end of the grant cycle.
//
//   Ports
//     i_clk, i_rst_n       clock / asynchronous active-low reset
//     i_fetch_req/addr     read request from the fetch stage
//     o_fetch_gnt          this cycle's read is accepted
//     o_fetch_valid/instr  read data, 2 cycles after the accepting cycle
//     o_fetch_err          with o_fetch_valid: address out of range, data 0
//     i_load_req/addr/data write request from the loader
//     o_load_gnt           this cycle's write is accepted
//     o_load_err           with o_load_gnt: address out of range, no write
//     o_iram_addr          iram address (holds when nothing is accessed)
//     o_iram_rnw           1 = read / idle, 0 = write
//     io_iram_data         shared data bus, driven here only while writing
// ----------------------------------------------------------------------------
module iram_access_ctrl
    import iram_access_ctrl_pkg::*;
#(
    parameter int ADDRESS_BUS_WIDTH = DEF_ADDRESS_BUS_WIDTH,
    parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
    parameter int IRAM_DEPTH        = DEF_IRAM_DEPTH,
    parameter int MAX_LOAD_RUN      = DEF_MAX_LOAD_RUN
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_fetch_req,
    input  logic [ADDRESS_BUS_WIDTH-1:0] i_fetch_addr,
    output logic                         o_fetch_gnt,
    output logic                         o_fetch_valid,
    output logic [INSTRUCTION_WIDTH-1:0] o_fetch_instr,
    output logic                         o_fetch_err,
    input  logic                         i_load_req,
    input  logic [ADDRESS_BUS_WIDTH-1:0] i_load_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] i_load_data,
    output logic                         o_load_gnt,
    output logic                         o_load_err,
    output logic [ADDRESS_BUS_WIDTH-1:0] o_iram_addr,
    output logic                         o_iram_rnw,
    inout  wire  [INSTRUCTION_WIDTH-1:0] io_iram_data
);

    localparam logic [ADDRESS_BUS_WIDTH-1:0] DEPTH_LIMIT = ADDRESS_BUS_WIDTH'(IRAM_DEPTH);

    grant_e                         w_grant;
    grant_e                         r_gstate;
    logic                           w_fetchOor;
    logic                           w_loadOor;
    logic                           w_fetchGnt;
    logic                           w_loadGnt;
    logic                           w_loadErr;
    logic                           w_doRead;
    logic                           w_doWrite;
    logic                           w_errIn;
    logic [ADDRESS_BUS_WIDTH-1:0]   w_iramAddr;
    logic [ADDRESS_BUS_WIDTH-1:0]   r_lastAddr;
    logic                           r_err0;
    logic                           r_vld1;
    logic                           r_err1;
    logic [INSTRUCTION_WIDTH-1:0]   r_instr;

    iram_arb_prio #(
        .MAX_LOAD_RUN (MAX_LOAD_RUN)
    ) u_arb (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_fetch_req (i_fetch_req),
        .i_load_req  (i_load_req),
        .o_grant     (w_grant)
    );

    assign w_fetchOor = (i_fetch_addr >= DEPTH_LIMIT);
    assign w_loadOor  = (i_load_addr  >= DEPTH_LIMIT);

    // Grant state register: remembers which requester owned the port in the
    // previous cycle, which is what tells the read pipe to capture the bus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gstate <= G_IDLE;
        end else begin
            r_gstate <= w_grant;
        end
    end

    // Decode the grant into port controls. Everything is gated with i_rst_n
    // so that reset releases the bus and drops the grants immediately rather
    // than at the next edge. Out-of-range requests are granted but never
    // touch the iram.
    always_comb begin
        w_fetchGnt = 1'b0;
        w_loadGnt  = 1'b0;
        w_loadErr  = 1'b0;
        w_doRead   = 1'b0;
        w_doWrite  = 1'b0;
        w_errIn    = 1'b0;
        if (i_rst_n) begin
            case (w_grant)
                G_FETCH: begin
                    w_fetchGnt = 1'b1;
                    w_doRead   = !w_fetchOor;
                    w_errIn    = w_fetchOor;
                end
                G_LOAD: begin
                    w_loadGnt  = 1'b1;
                    w_loadErr  = w_loadOor;
                    w_doWrite  = !w_loadOor;
                end
                default: begin
                end
            endcase
        end
    end

    // The address only moves for a real access; idle cycles and dropped
    // out-of-range requests leave the last address on the bus.
    always_comb begin
        w_iramAddr = r_lastAddr;
        if (w_doWrite) begin
            w_iramAddr = i_load_addr;
        end else if (w_doRead) begin
            w_iramAddr = i_fetch_addr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lastAddr <= '0;
        end else if (w_doWrite || w_doRead) begin
            r_lastAddr <= w_iramAddr;
        end
    end

    // Two-stage read pipe. Stage 0 is the grant cycle (its valid bit is the
    // registered grant state, its error bit is r_err0); stage 1 captures the
    // iram's registered word from the bus one cycle later. Out-of-range
    // reads return zero in place of whatever is on the bus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err0  <= 1'b0;
            r_vld1  <= 1'b0;
            r_err1  <= 1'b0;
            r_instr <= '0;
        end else begin
            r_err0 <= w_errIn;
            r_vld1 <= (r_gstate == G_FETCH);
            r_err1 <= r_err0;
            if (r_gstate == G_FETCH) begin
                r_instr <= r_err0 ? '0 : io_iram_data;
            end
        end
    end

    assign o_fetch_gnt   = w_fetchGnt;
    assign o_load_gnt    = w_loadGnt;
    assign o_load_err    = w_loadErr;
    assign o_fetch_valid = r_vld1;
    assign o_fetch_err   = r_err1;
    assign o_fetch_instr = r_instr;
    assign o_iram_addr   = w_iramAddr;
    assign o_iram_rnw    = !w_doWrite;

    // The iram gates its own read driver with read_not_write, so the bus can
    // flip direction between consecutive cycles without a dead cycle.
    assign io_iram_data  = w_doWrite ? i_load_data : {INSTRUCTION_WIDTH{1'bz}};

endmodule

// File: tb/tb_iram_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_iram_access_ctrl
//   Directed and random stimulus for iram_access_ctrl with a behavioural
//   instruction RAM on the shared bus and a reference model of the grant
//   rules, memory contents and read latency kept inside the bench.
// ----------------------------------------------------------------------------
module tb_iram_access_ctrl;

    localparam int AW       = 24;
    localparam int IW       = 36;
    localparam int DEPTH    = 64;
    localparam int MAX_RUN  = 4;

    logic          clk;
    logic          rstN;
    logic          fetchReq;
    logic [AW-1:0] fetchAddr;
    logic          fetchGnt;
    logic          fetchValid;
    logic [IW-1:0] fetchInstr;
    logic          fetchErr;
    logic          loadReq;
    logic [AW-1:0] loadAddr;
    logic [IW-1:0] loadData;
    logic          loadGnt;
    logic          loadErr;
    logic [AW-1:0] iramAddr;
    logic          iramRnw;
    wire  [IW-1:0] iramData;

    int assertCount;
    int failCount;

    iram_access_ctrl #(
        .ADDRESS_BUS_WIDTH (AW),
        .INSTRUCTION_WIDTH (IW),
        .IRAM_DEPTH        (DEPTH),
        .MAX_LOAD_RUN      (MAX_RUN)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_fetch_req   (fetchReq),
        .i_fetch_addr  (fetchAddr),
        .o_fetch_gnt   (fetchGnt),
        .o_fetch_valid (fetchValid),
        .o_fetch_instr (fetchInstr),
        .o_fetch_err   (fetchErr),
        .i_load_req    (loadReq),
        .i_load_addr   (loadAddr),
        .i_load_data   (loadData),
        .o_load_gnt    (loadGnt),
        .o_load_err    (loadErr),
        .o_iram_addr   (iramAddr),
        .o_iram_rnw    (iramRnw),
        .io_iram_data  (iramData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural iram: registered read, write at the end of a write cycle,
    // read driver enabled only while read_not_write is high.
    logic [IW-1:0] iramMem [0:DEPTH-1];
    logic [IW-1:0] iramRdReg;
    logic          memClear;

    assign iramData = iramRnw ? iramRdReg : {IW{1'bz}};

    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < DEPTH; i++) iramMem[i] <= '0;
            iramRdReg <= '0;
        end else if (!iramRnw) begin
            if (iramAddr < AW'(DEPTH)) iramMem[iramAddr[5:0]] <= iramData;
        end else if (iramAddr < AW'(DEPTH)) begin
            iramRdReg <= iramMem[iramAddr[5:0]];
        end
    end

    // Reference model state.
    logic [IW-1:0] refMem [0:DEPTH-1];
    logic [1:0]    pVld;
    logic [1:0]    pErr;
    logic [1:0]    pDc;
    logic [IW-1:0] pData [0:1];
    int            loadsWhileWaiting;
    logic [AW-1:0] refLastAddr;
    logic          lastLoadGnt;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        pVld = '0;
        pErr = '0;
        pDc = '0;
        pData[0] = '0;
        pData[1] = '0;
        loadsWhileWaiting = 0;
        refLastAddr = '0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_fetch_valid"}, 64'(fetchValid), 64'd0);
        checkOutput({tag, "_fetch_err"}, 64'(fetchErr), 64'd0);
        checkOutput({tag, "_fetch_instr"}, 64'(fetchInstr), 64'd0);
        checkOutput({tag, "_load_err"}, 64'(loadErr), 64'd0);
        checkOutput({tag, "_fetch_gnt"}, 64'(fetchGnt), 64'd0);
        checkOutput({tag, "_load_gnt"}, 64'(loadGnt), 64'd0);
        checkOutput({tag, "_iram_rnw"}, 64'(iramRnw), 64'd1);
        checkOutput({tag, "_bus_released"}, 64'(iramData), 64'(iramRdReg));
    endtask

    // One clock cycle: drive requests just after the falling edge, check all
    // outputs against the model, advance the model, wait for the next falling
    // edge.
    task automatic applyStimulus(input logic fr, input logic [AW-1:0] fa,
                                 input logic lr, input logic [AW-1:0] la,
                                 input logic [IW-1:0] ld);
        logic fOor;
        logic lOor;
        logic expF;
        logic expL;
        logic expWr;
        fetchReq  = fr;
        fetchAddr = fa;
        loadReq   = lr;
        loadAddr  = la;
        loadData  = ld;
        #1;
        checkOutput("fetch_valid", 64'(fetchValid), 64'(pVld[1]));
        checkOutput("fetch_err", 64'(fetchErr), 64'(pVld[1] && pErr[1]));
        if (pVld[1] && (!pDc[1] || pErr[1])) begin
            checkOutput("fetch_instr", 64'(fetchInstr), 64'(pData[1]));
        end
        fOor  = (fa >= AW'(DEPTH));
        lOor  = (la >= AW'(DEPTH));
        expL  = lr && !(fr && loadsWhileWaiting >= MAX_RUN);
        expF  = fr && !expL;
        expWr = expL && !lOor;
        if (expWr) refLastAddr = la;
        else if (expF && !fOor) refLastAddr = fa;
        checkOutput("fetch_gnt", 64'(fetchGnt), 64'(expF));
        checkOutput("load_gnt", 64'(loadGnt), 64'(expL));
        checkOutput("load_err", 64'(loadErr), 64'(expL && lOor));
        checkOutput("iram_rnw", 64'(iramRnw), 64'(!expWr));
        checkOutput("iram_addr", 64'(iramAddr), 64'(refLastAddr));
        checkOutput("iram_data", 64'(iramData), expWr ? 64'(ld) : 64'(iramRdReg));
        lastLoadGnt = loadGnt;
        // A write in the capture cycle takes the bus away from the iram's
        // read word, so that returned word is not predictable.
        pVld[1]  = pVld[0];
        pErr[1]  = pErr[0];
        pData[1] = pData[0];
        pDc[1]   = expWr;
        pVld[0]  = expF;
        pErr[0]  = expF && fOor;
        pData[0] = (expF && !fOor) ? refMem[fa[5:0]] : '0;
        pDc[0]   = 1'b0;
        if (expWr) refMem[la[5:0]] = ld;
        if (!fr || expF) loadsWhileWaiting = 0;
        else if (expL) loadsWhileWaiting++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        assertCount = 0;
        failCount   = 0;
        lastLoadGnt = 1'b0;
        for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
        modelReset();
        rstN      = 1'b0;
        memClear  = 1'b1;
        fetchReq  = 1'b0;
        fetchAddr = '0;
        loadReq   = 1'b0;
        loadAddr  = '0;
        loadData  = '0;

        // Reset values
        repeat (3) @(negedge clk);
        checkReset("reset");
        memClear = 1'b0;
        rstN     = 1'b1;
        $display("[TB] reset released");

        // Load two words, then fetch them back-to-back
        applyStimulus(0, 0, 1, 24'd0, 36'h011000010);
        applyStimulus(0, 0, 1, 24'd1, 36'h012000020);
        applyStimulus(1, 24'd0, 0, 0, 0);
        applyStimulus(1, 24'd1, 0, 0, 0);
        checkOutput("ldfetch_word0", 64'(fetchInstr), 64'h011000010);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("ldfetch_word1", 64'(fetchInstr), 64'h012000020);
        checkOutput("ldfetch_valid1", 64'(fetchValid), 64'd1);
        applyStimulus(0, 0, 0, 0, 0);

        // Write then read of the same address in the next cycle
        applyStimulus(0, 0, 1, 24'd5, 36'h052210000);
        applyStimulus(1, 24'd5, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("hazard_word", 64'(fetchInstr), 64'h052210000);
        applyStimulus(0, 0, 0, 0, 0);

        // Both requesters held high: four loads then one fetch, repeating
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1, 24'd20, 1, AW'(30 + i), IW'(36'h0A0000000 + i));
            checkOutput("starve_pattern", 64'(lastLoadGnt), 64'((i % 5) != 4));
        end
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Range checks; the dropped load at 70 must not alias onto word 6
        applyStimulus(0, 0, 1, 24'd6, 36'h066006600);
        applyStimulus(1, 24'd64, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("range_fetch_err", 64'(fetchErr), 64'd1);
        checkOutput("range_fetch_instr", 64'(fetchInstr), 64'd0);
        applyStimulus(0, 0, 1, 24'd70, 36'hBADBADBAD);
        applyStimulus(1, 24'd6, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("range_readback", 64'(fetchInstr), 64'h066006600);

        // Idle cycles
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0);

        // Random traffic, including out-of-range addresses
        for (int i = 0; i < 300; i++) begin
            logic [IW-1:0] rd;
            rd = {4'($urandom), $urandom};
            applyStimulus(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 71)),
                          1'($urandom_range(0, 2) != 0), AW'($urandom_range(0, 71)), rd);
        end
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Reset asserted in the middle of a write cycle, with a read in flight
        applyStimulus(1, 24'd2, 0, 0, 0);
        fetchReq = 1'b0;
        loadReq  = 1'b1;
        loadAddr = 24'd3;
        loadData = 36'h0DEAD0003;
        #1;
        checkOutput("midwrite_load_gnt", 64'(loadGnt), 64'd1);
        checkOutput("midwrite_rnw_before", 64'(iramRnw), 64'd0);
        #1;
        rstN = 1'b0;
        #1;
        checkReset("midwrite");
        @(negedge clk);
        modelReset();
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
